modulo_down_counter: RTL and testbench



---
 rtl/modulo_down_counter_if.sv | 24 ++
 rtl/modulo_down_counter.sv | 81 ++++++++
 tb/tb_modulo_down_counter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/modulo_down_counter_if.sv
// Control and count bus for modulo_down_counter: preset/control inputs
// and the registered count, borrow and busy outputs.
interface modulo_down_counter_if #(
  parameter int unsigned WIDTH = 3
);
  logic             Start;
  logic             Dec;
  logic             Load;
  logic [WIDTH-1:0] D;
  logic             Mode;
  logic [WIDTH-1:0] B;
  logic             Q;
  logic             Busy;

  modport master (
    output Start, Dec, Load, D, Mode,
    input  B, Q, Busy
  );

  modport slave (
    input  Start, Dec, Load, D, Mode,
    output B, Q, Busy
  );
endinterface

// File: rtl/modulo_down_counter.sv
// Modulo-N down counter with borrow pulse. Counts a preset down to 0 on
// each Dec tick, then wraps to MODULUS-1 (Mode=0) or stops in DONE
// (Mode=1). Every underflow produces a one-cycle registered borrow on Q.
module modulo_down_counter #(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned MODULUS = 6
) (
  input logic                  Store,
  input logic                  Reset,
  modulo_down_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             q_q, q_d;
  logic             underflow;
  logic [WIDTH-1:0] load_val;

  // State, count and borrow registers; asynchronous active-low reset.
  always_ff @(posedge Store or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      b_q     <= TOP;
      q_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      q_q     <= q_d;
    end
  end

  // Next-state logic; Load suppresses the Dec tick, so it also blocks RUN->DONE.
  always_comb begin
    state_d   = state_q;
    underflow = (state_q == RUN) && bus.Dec && !bus.Load && (b_q == '0);
    unique case (state_q)
      IDLE:    if (bus.Start) state_d = RUN;
      RUN:     if (underflow && bus.Mode) state_d = DONE;
      DONE:    if (bus.Start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Count and borrow next values; preset is clamped into the legal count range.
  always_comb begin
    b_d      = b_q;
    q_d      = 1'b0;
    load_val = ({1'b0, bus.D} >= MOD_EXT) ? TOP : bus.D;
    if (bus.Load) begin
      b_d = load_val;
    end else if (state_q == RUN) begin
      if (bus.Dec) begin
        if (b_q != '0) begin
          b_d = b_q - 1'b1;
        end else begin
          b_d = bus.Mode ? '0 : TOP;
          q_d = 1'b1;
        end
      end
    end else if ((state_q == DONE) && bus.Start) begin
      b_d = TOP;
    end
  end

  // Outputs come straight from registers; Busy decodes the state register.
  always_comb begin
    bus.B    = b_q;
    bus.Q    = q_q;
    bus.Busy = (state_q == RUN);
  end

endmodule

// File: tb/tb_modulo_down_counter.sv
// Scoreboard bench for modulo_down_counter (WIDTH=3, MODULUS=6). Stimulus
// pushes the hand-computed response for each edge; a monitor pops and
// compares one cycle later.
module tb_modulo_down_counter;

  logic clk;
  logic rst_n;

  modulo_down_counter_if #(.WIDTH(3)) bus_if ();

  modulo_down_counter #(.WIDTH(3), .MODULUS(6)) dut (
    .Store (clk),
    .Reset (rst_n),
    .bus   (bus_if.slave)
  );

  typedef struct {
    logic [2:0] b;
    logic       q;
    logic       busy;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [2:0] per_b [13] = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd5, 3'd4,
                             3'd3, 3'd2, 3'd1, 3'd0, 3'd5, 3'd4};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [2:0] eb, input logic eq,
                       input logic eby);
    n_cmp++;
    if (bus_if.B !== eb || bus_if.Q !== eq || bus_if.Busy !== eby) begin
      n_bad++;
      $display("FAIL %s: got B=%0d Q=%0b Busy=%0b, want B=%0d Q=%0b Busy=%0b",
               nm, bus_if.B, bus_if.Q, bus_if.Busy, eb, eq, eby);
    end
  endtask

  // Monitor: one response per edge, sampled 1 time unit after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.name, e.b, e.q, e.busy);
      end
    end
  end

  task automatic step(input logic st, input logic dc, input logic ld,
                      input logic [2:0] d, input logic md,
                      input logic [2:0] eb, input logic eq, input logic eby,
                      input string nm);
    exp_t e;
    @(posedge clk);
    #2;
    bus_if.Start = st;
    bus_if.Dec   = dc;
    bus_if.Load  = ld;
    bus_if.D     = d;
    bus_if.Mode  = md;
    e.b = eb; e.q = eq; e.busy = eby; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (sb.size() > 0 && n < 10) begin
      @(posedge clk);
      #3;
      n++;
    end
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, want finish before 100000");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n        = 1'b1;
    bus_if.Start = 1'b0;
    bus_if.Dec   = 1'b0;
    bus_if.Load  = 1'b0;
    bus_if.D     = '0;
    bus_if.Mode  = 1'b0;
    #1 rst_n = 1'b0;
    #1 check("reset_initial", 3'd5, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Presets in IDLE, including out-of-range clamp and ignored Dec
    step(0, 0, 1, 3'd3, 0, 3'd3, 0, 0, "load3");
    step(0, 0, 1, 3'd7, 0, 3'd5, 0, 0, "load7_clamp");
    step(0, 1, 0, 3'd0, 0, 3'd5, 0, 0, "idle_dec_ignored");
    step(1, 0, 0, 3'd0, 0, 3'd5, 0, 1, "start_run");

    // Periodic wrap: 13 ticks
    for (int i = 0; i < 13; i++)
      step(0, 1, 0, 3'd0, 0, per_b[i], (i == 5 || i == 11), 1,
           $sformatf("periodic_%0d", i));

    step(1, 0, 0, 3'd0, 0, 3'd4, 0, 1, "start_in_run_ignored");

    // Gapped ticks down through wrap
    step(0, 1, 0, 3'd0, 0, 3'd3, 0, 1, "gap_pre3");
    step(0, 1, 0, 3'd0, 0, 3'd2, 0, 1, "gap_pre2");
    step(0, 1, 0, 3'd0, 0, 3'd1, 0, 1, "gap_pre1");
    step(0, 1, 0, 3'd0, 0, 3'd0, 0, 1, "gap_dec_to0");
    step(0, 0, 0, 3'd0, 0, 3'd0, 0, 1, "gap_hold0");
    step(0, 1, 0, 3'd0, 0, 3'd5, 1, 1, "gap_wrap");
    step(0, 0, 0, 3'd0, 0, 3'd5, 0, 1, "gap_hold5");

    // Load beats Dec at B=0 in RUN
    step(0, 0, 1, 3'd0, 0, 3'd0, 0, 1, "load0_run");
    step(0, 1, 1, 3'd3, 0, 3'd3, 0, 1, "load_prio_over_dec");

    // One-shot
    step(0, 0, 1, 3'd2, 1, 3'd2, 0, 1, "oneshot_load2");
    step(0, 1, 0, 3'd0, 1, 3'd1, 0, 1, "oneshot_1");
    step(0, 1, 0, 3'd0, 1, 3'd0, 0, 1, "oneshot_0");
    step(0, 1, 0, 3'd0, 1, 3'd0, 1, 0, "oneshot_underflow");
    step(0, 1, 0, 3'd0, 1, 3'd0, 0, 0, "done_dec_ignored_a");
    step(0, 1, 0, 3'd0, 1, 3'd0, 0, 0, "done_dec_ignored_b");
    step(1, 0, 0, 3'd0, 1, 3'd5, 0, 1, "done_restart");

    // Back to DONE, then Load+Start on the same edge
    step(0, 0, 1, 3'd0, 1, 3'd0, 0, 1, "load0_again");
    step(0, 1, 0, 3'd0, 1, 3'd0, 1, 0, "oneshot_underflow2");
    step(1, 0, 1, 3'd4, 0, 3'd4, 0, 1, "done_load_start");
    step(0, 1, 0, 3'd0, 0, 3'd3, 0, 1, "pre_reset_3");
    step(0, 1, 0, 3'd0, 0, 3'd2, 0, 1, "pre_reset_2");
    drain();

    // Asynchronous reset mid-count
    rst_n = 1'b0;
    #1 check("reset_async_midrun", 3'd5, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    step(0, 1, 0, 3'd0, 0, 3'd5, 0, 0, "post_reset_idle_dec");
    step(1, 0, 0, 3'd0, 0, 3'd5, 0, 1, "post_reset_start");
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
